// File: rtl/risc_v_mike_data_mem_mmio.sv
// Byte-addressed data memory for the MEM stage with a memory-mapped,
// multi-channel GPIO block: synchronised inputs, set/clear/toggle of the
// output registers, and sticky rising-edge flags that drive one interrupt.
module risc_v_mike_data_mem_mmio #(
    parameter int                          DATA_MEM_DEPTH = 64,
    parameter int                          GPIO_CH        = 2,
    parameter int                          GPIO_W         = 32,
    parameter logic [31:0]                 MMIO_BASE      = 32'h0000_1000,
    parameter logic [GPIO_CH*GPIO_W-1:0]   GPIO_OUT_RST   = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 data_mem_addr,
    input  logic                        data_mem_write,
    input  logic                        data_mem_read,
    input  logic [2:0]                  data_mem_size,
    input  logic [31:0]                 data_mem_wr_data,
    output logic [31:0]                 data_mem_rd_data,
    output logic                        data_mem_err,
    output logic [GPIO_CH*GPIO_W-1:0]   gpio_out,
    input  logic [GPIO_CH*GPIO_W-1:0]   gpio_in,
    output logic                        gpio_irq
);

    localparam int          AW        = $clog2(DATA_MEM_DEPTH);
    localparam int          PW        = GPIO_CH * GPIO_W;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DATA_MEM_DEPTH);
    localparam logic [31:0] MMIO_END  = MMIO_BASE + 32'(32 * GPIO_CH);

    // Register offsets inside one 32-byte channel window, as word indices.
    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_SET  = 3'd1;
    localparam logic [2:0] REG_CLR  = 3'd2;
    localparam logic [2:0] REG_TGL  = 3'd3;
    localparam logic [2:0] REG_IN   = 3'd4;
    localparam logic [2:0] REG_EDGE = 3'd5;

    logic [31:0]        mem [DATA_MEM_DEPTH];
    logic [GPIO_W-1:0]  out_q  [GPIO_CH];
    logic [GPIO_W-1:0]  edge_q [GPIO_CH];
    logic [PW-1:0]      sync_meta, in_sync, in_prev;

    logic               is_byte, is_half, is_word, ld_signed;
    logic               in_ram, in_gpio, misaligned, bad;
    logic               wr_ram, wr_gpio;
    logic [2:0]         chan, reg_sel;
    logic [AW-1:0]      word_idx;
    logic [GPIO_W-1:0]  gpio_wd;
    logic [3:0]         byte_en;
    logic [31:0]        ram_wd;

    // Access decode: size class, region, alignment and the error condition.
    always_comb begin
        is_byte    = (data_mem_size[1:0] == 2'b00);
        is_half    = (data_mem_size[1:0] == 2'b01);
        is_word    = ~is_byte & ~is_half;   // W and every undefined funct3
        ld_signed  = ~data_mem_size[2];
        in_ram     = (data_mem_addr < RAM_BYTES);
        in_gpio    = (data_mem_addr >= MMIO_BASE) && (data_mem_addr < MMIO_END);
        misaligned = (is_half & data_mem_addr[0]) | (is_word & (|data_mem_addr[1:0]));
        bad        = misaligned | ~(in_ram | in_gpio) | (in_gpio & ~is_word);
        wr_ram     = data_mem_write & ~bad & in_ram;
        wr_gpio    = data_mem_write & ~bad & in_gpio;
        chan       = data_mem_addr[7:5];
        reg_sel    = data_mem_addr[4:2];
        word_idx   = data_mem_addr[AW+1:2];
        gpio_wd    = data_mem_wr_data[GPIO_W-1:0];
    end

    assign data_mem_err = (data_mem_read | data_mem_write) & bad;

    // Store lane steering: replicate the LSB-aligned data across lanes and
    // enable only the lanes the access covers.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        byte_en = 4'b0000;
        ram_wd  = data_mem_wr_data;
        if (is_byte) begin
            byte_en[data_mem_addr[1:0]] = 1'b1;
            ram_wd = {4{data_mem_wr_data[7:0]}};
        end else if (is_half) begin
            byte_en = data_mem_addr[1] ? 4'b1100 : 4'b0011;
            ram_wd  = {2{data_mem_wr_data[15:0]}};
        end else begin
            byte_en = 4'b1111;
        end
    end

    // RAM array: cleared on reset, byte-lane writes otherwise.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the RAM must read zero after reset, so the array is reset
        // explicitly; this rules out block-RAM inference and costs a wide reset fan-out.
        if (rst) begin
            for (int i = 0; i < DATA_MEM_DEPTH; i++) mem[i] <= '0;
        end else if (wr_ram) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= ram_wd[8*b +: 8];
        end
    end

    // Two-flop input synchroniser plus the delayed copy used for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make each stage take the previous
        // stage's old value, which is what builds the flop chain.
        if (rst) begin
            sync_meta <= '0;
            in_sync   <= '0;
            in_prev   <= '0;
        end else begin
            sync_meta <= gpio_in;
            in_sync   <= sync_meta;
            in_prev   <= in_sync;
        end
    end

    // OUT registers with atomic set/clear/toggle; EDGE flags with W1C where a
    // coincident rising edge wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < GPIO_CH; c++) begin
                out_q[c]  <= GPIO_OUT_RST[c*GPIO_W +: GPIO_W];
                edge_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < GPIO_CH; c++) begin
                if (wr_gpio && chan == 3'(c)) begin
                    case (reg_sel)
                        REG_OUT: out_q[c] <= gpio_wd;
                        REG_SET: out_q[c] <= out_q[c] | gpio_wd;
                        REG_CLR: out_q[c] <= out_q[c] & ~gpio_wd;
                        REG_TGL: out_q[c] <= out_q[c] ^ gpio_wd;
                        default: ;
                    endcase
                end
                edge_q[c] <= (edge_q[c] & ~((wr_gpio && chan == 3'(c) && reg_sel == REG_EDGE)
                                            ? gpio_wd : '0))
                           | (in_sync[c*GPIO_W +: GPIO_W] & ~in_prev[c*GPIO_W +: GPIO_W]);
            end
        end
    end

    // Flatten OUT registers onto the pin bus and OR all edge flags.
    always_comb begin
        gpio_irq = 1'b0;
        for (int c = 0; c < GPIO_CH; c++) begin
            gpio_out[c*GPIO_W +: GPIO_W] = out_q[c];
            gpio_irq = gpio_irq | (|edge_q[c]);
        end
    end

    logic [31:0]       ram_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [GPIO_W-1:0] gpio_rd;

    // Combinational load path: lane select and extension for RAM, register
    // select for GPIO, forced to zero on any bad access.
    always_comb begin
        ram_word         = mem[word_idx];
        ld_byte          = 8'(ram_word >> {data_mem_addr[1:0], 3'b000});
        ld_half          = data_mem_addr[1] ? ram_word[31:16] : ram_word[15:0];
        gpio_rd          = '0;
        data_mem_rd_data = '0;
        if (in_ram) begin
            if (is_byte)
                data_mem_rd_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            else if (is_half)
                data_mem_rd_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            else
                data_mem_rd_data = ram_word;
        end else if (in_gpio) begin
            for (int c = 0; c < GPIO_CH; c++) begin
                if (chan == 3'(c)) begin
                    case (reg_sel)
                        REG_OUT:  gpio_rd = out_q[c];
                        REG_IN:   gpio_rd = in_sync[c*GPIO_W +: GPIO_W];
                        REG_EDGE: gpio_rd = edge_q[c];
                        default:  gpio_rd = '0;
                    endcase
                end
            end
            data_mem_rd_data[GPIO_W-1:0] = gpio_rd;
        end
        if (bad) data_mem_rd_data = '0;
    end

endmodule

// File: tb/tb_risc_v_mike_data_mem_mmio.sv
// Self-checking bench for risc_v_mike_data_mem_mmio: directed steps from the
// test plan followed by randomized accesses, all compared against a
// byte-array / per-channel reference model.
module tb_risc_v_mike_data_mem_mmio;

    localparam int          DEPTH   = 64;
    localparam int          CH      = 2;
    localparam int          W       = 32;
    localparam logic [63:0] RST_VAL = 64'h1234_5678_0000_0000;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [2:0]  SB = 3'b000, SH = 3'b001, SW = 3'b010, SBU = 3'b100, SHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        wr, rd, err, irq;
    logic [2:0]  size;
    logic [63:0] gout, pins;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc_v_mike_data_mem_mmio #(
        .DATA_MEM_DEPTH(DEPTH), .GPIO_CH(CH), .GPIO_W(W),
        .MMIO_BASE(BASE), .GPIO_OUT_RST(RST_VAL)
    ) dut (
        .clk(clk), .rst(rst),
        .data_mem_addr(addr), .data_mem_write(wr), .data_mem_read(rd),
        .data_mem_size(size), .data_mem_wr_data(wdata),
        .data_mem_rd_data(rdata), .data_mem_err(err),
        .gpio_out(gout), .gpio_in(pins), .gpio_irq(irq)
    );

    // ---------------- reference model ----------------
    logic [7:0]  mb [256];          // RAM as plain bytes, little-endian
    logic [31:0] mout [CH];
    logic [31:0] medge [CH];
    logic [63:0] seen1, seen2, seen3; // pins as sampled 1, 2 and 3 edges ago

    function automatic int unsigned nbytes(logic [2:0] s);
        if (s[1:0] == 2'b00) return 1;
        if (s[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_err(logic [31:0] a, logic [2:0] s);
        int unsigned n = nbytes(s);
        bit ram = (a < 32'd256);
        bit gp  = (a >= BASE) && (a < BASE + 32'd64);
        return ((a % n) != 0) || !(ram || gp) || (gp && n != 4);
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] a, logic [2:0] s);
        int unsigned n = nbytes(s);
        logic [31:0] v = '0;
        logic [31:0] mask;
        int ch;
        if (m_err(a, s)) return '0;
        if (a >= BASE) begin
            ch = int'((a - BASE) / 32);
            case (a % 32)
                0:  return mout[ch];
                16: return seen2[ch*32 +: 32];
                20: return medge[ch];
                default: return '0;
            endcase
        end
        for (int i = 0; i < int'(n); i++) v = v | (32'(mb[a + 32'(i)]) << (8 * i));
        if (n < 4 && !s[2] && v[8*n-1]) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v | ~mask;
        end
        return v;
    endfunction

    task automatic model_reset();
        logic [63:0] rv = RST_VAL;
        for (int i = 0; i < 256; i++) mb[i] = '0;
        for (int c = 0; c < CH; c++) begin
            mout[c]  = rv[c*32 +: 32];
            medge[c] = '0;
        end
        seen1 = '0; seen2 = '0; seen3 = '0;
    endtask

    // What one rising edge does, given the inputs currently driven.
    task automatic model_edge();
        logic [31:0] clr [CH];
        int ch;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) clr[c] = '0;
        if (wr && !m_err(addr, size)) begin
            if (addr < 32'd256) begin
                for (int i = 0; i < int'(nbytes(size)); i++) mb[addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                ch = int'((addr - BASE) / 32);
                case (addr % 32)
                    0:  mout[ch] = wdata;
                    4:  mout[ch] = mout[ch] | wdata;
                    8:  mout[ch] = mout[ch] & ~wdata;
                    12: mout[ch] = mout[ch] ^ wdata;
                    20: clr[ch]  = wdata;
                    default: ;
                endcase
            end
        end
        for (int c = 0; c < CH; c++)
            medge[c] = (medge[c] & ~clr[c]) | (seen2[c*32 +: 32] & ~seen3[c*32 +: 32]);
        seen3 = seen2;
        seen2 = seen1;
        seen1 = pins;
    endtask

    // ---------------- helpers ----------------
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(logic w, logic r, logic [2:0] s, logic [31:0] a, logic [31:0] d);
        wr = w; rd = r; size = s; addr = a; wdata = d;
        #1;
    endtask

    task automatic check_model(string tag);
        check({tag, ".err"}, 64'(err), 64'((wr | rd) & m_err(addr, size)));
        if (rd) check({tag, ".rd"}, 64'(rdata), 64'(m_load(addr, size)));
        check({tag, ".out"}, gout, {mout[1], mout[0]});
        check({tag, ".irq"}, 64'(irq), 64'((|medge[0]) | (|medge[1])));
    endtask

    task automatic op(string tag, logic w, logic r, logic [2:0] s, logic [31:0] a, logic [31:0] d);
        drive(w, r, s, a, d);
        check_model(tag);
        step();
    endtask

    // Load with an explicit expected value as well as the model check.
    task automatic ld(string tag, logic [2:0] s, logic [31:0] a, logic [31:0] exp);
        drive(1'b0, 1'b1, s, a, 32'h0);
        check(tag, 64'(rdata), 64'(exp));
        check_model(tag);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] szs [8] = '{SB, SH, SW, SBU, SHU, SW, 3'd3, 3'd7};
        logic [31:0] a;
        logic [2:0]  s;
        int r;

        // ---- reset ----
        rst = 1'b1; pins = '0;
        drive(1'b0, 1'b0, SW, 32'h0, 32'h0);
        model_reset();
        check("rst.out_async", gout, RST_VAL);
        check("rst.irq", 64'(irq), 64'h0);
        step(); step();
        rst = 1'b0;
        ld("rst.ram0", SW, 32'h0, 32'h0);
        ld("rst.set_reg", SW, 32'h1004, 32'h0);
        check("rst.out", gout, RST_VAL);

        // ---- RAM byte/half/word ----
        op("sw10", 1'b1, 1'b0, SW, 32'h10, 32'h8000_00F5);
        ld("lb10", SB, 32'h10, 32'hFFFF_FFF5);
        ld("lbu10", SBU, 32'h10, 32'h0000_00F5);
        ld("lh12", SH, 32'h12, 32'hFFFF_8000);
        ld("lhu12", SHU, 32'h12, 32'h0000_8000);
        op("sb11", 1'b1, 1'b0, SB, 32'h11, 32'hAAAA_AA12);
        ld("lw10", SW, 32'h10, 32'h8000_12F5);

        // ---- GPIO OUT set/clear/toggle ----
        op("out0", 1'b1, 1'b0, SW, 32'h1000, 32'hF0);
        check("out0.val", 64'(gout[31:0]), 64'h0F0);
        op("set0", 1'b1, 1'b0, SW, 32'h1004, 32'h0F);
        check("set0.val", 64'(gout[31:0]), 64'h0FF);
        op("clr0", 1'b1, 1'b0, SW, 32'h1008, 32'h30);
        check("clr0.val", 64'(gout[31:0]), 64'h0CF);
        op("tgl0", 1'b1, 1'b0, SW, 32'h100C, 32'h01);
        check("tgl0.val", 64'(gout[31:0]), 64'h0CE);
        check("ch1.untouched", 64'(gout[63:32]), 64'h1234_5678);
        ld("set.reads0", SW, 32'h1004, 32'h0);

        // ---- input synchroniser and edge flag timing ----
        pins[32] = 1'b1;                        // changes before edge N
        ld("in1.after_n", SW, 32'h1030, 32'h0);   // cycle ends at edge N
        ld("in1.after_n1", SW, 32'h1030, 32'h0);  // read after N, before N+1
        ld("in1.sync", SW, 32'h1030, 32'h1);      // read after N+1
        ld("edge1.set", SW, 32'h1034, 32'h1);     // read after N+2
        check("edge1.irq", 64'(irq), 64'h1);
        op("edge1.w1c", 1'b1, 1'b0, SW, 32'h1034, 32'h1);
        ld("edge1.cleared", SW, 32'h1034, 32'h0);
        check("edge1.irq_low", 64'(irq), 64'h0);
        pins[32] = 1'b0;
        repeat (3) op("idle", 1'b0, 1'b0, SW, 32'h0, 32'h0);
        pins[32] = 1'b1;                        // new rise before edge M
        op("idle.m", 1'b0, 1'b0, SW, 32'h0, 32'h0);
        op("idle.m1", 1'b0, 1'b0, SW, 32'h0, 32'h0);
        op("w1c.coincident", 1'b1, 1'b0, SW, 32'h1034, 32'h1); // ends at M+2
        ld("edge1.set_wins", SW, 32'h1034, 32'h1);
        check("edge1.irq_kept", 64'(irq), 64'h1);

        // ---- errors ----
        drive(1'b0, 1'b1, SW, 32'h2, 32'h0);
        check("lw2.err", 64'(err), 64'h1);  check("lw2.rd", 64'(rdata), 64'h0); step();
        drive(1'b0, 1'b1, SH, 32'h1, 32'h0);
        check("lh1.err", 64'(err), 64'h1);  check("lh1.rd", 64'(rdata), 64'h0); step();
        drive(1'b1, 1'b0, SB, 32'h1000, 32'hFF);
        check("sb_gpio.err", 64'(err), 64'h1); check_model("sb_gpio"); step();
        check("sb_gpio.out", 64'(gout[31:0]), 64'h0CE);
        drive(1'b0, 1'b1, SW, 32'h200, 32'h0);
        check("unmapped.err", 64'(err), 64'h1); check("unmapped.rd", 64'(rdata), 64'h0); step();
        op("sw_misaligned", 1'b1, 1'b0, SW, 32'h2, 32'hDEAD_BEEF);
        op("sw_unmapped", 1'b1, 1'b0, SW, 32'h100, 32'hDEAD_BEEF);
        ld("ram0.unchanged", SW, 32'h0, 32'h0);
        ld("ram_wrap.none", SW, 32'h10, 32'h8000_12F5);
        drive(1'b0, 1'b0, SW, 32'h2, 32'h0);
        check("idle.no_err", 64'(err), 64'h0);

        // ---- reset in the middle of a store stream ----
        op("stream0", 1'b1, 1'b0, SW, 32'h20, 32'h1111_1111);
        drive(1'b1, 1'b0, SW, 32'h24, 32'h2222_2222);
        rst = 1'b1;
        #1;
        check("midrst.out_async", gout, RST_VAL);
        check("midrst.irq_async", 64'(irq), 64'h0);
        step();
        rst = 1'b0;
        ld("midrst.edge", SW, 32'h1034, 32'h0);
        ld("midrst.ram20", SW, 32'h20, 32'h0);
        ld("midrst.ram24", SW, 32'h24, 32'h0);
        ld("midrst.ram10", SW, 32'h10, 32'h0);
        check("midrst.out", gout, RST_VAL);

        // ---- randomized accesses against the model ----
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) pins = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            s = szs[$urandom_range(0, 7)];
            if (r <= 5) begin
                a = 32'($urandom_range(0, 255));
            end else if (r <= 7) begin
                a = BASE + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0) begin
                    a[1:0] = 2'b00;
                    s = SW;
                end
            end else if (r == 8) begin
                a = 32'h100 + 32'($urandom_range(0, 32'hEFF));
            end else begin
                a = $urandom;
            end
            op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
